// File: rtl/centipede_pkg.sv
// Shared constants and state encoding for the Centipede NVRAM/ioctl bridge.
package centipede_pkg;

  localparam int unsigned NVRAM_ADDR_W = 6;
  localparam int unsigned NVRAM_DEPTH  = 1 << NVRAM_ADDR_W;
  localparam logic [7:0]  NVRAM_INDEX  = 8'd4;

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    XFER_DL,
    UL_RD,
    UL_CAP,
    UL_HOLD,
    RELEASE
  } nvram_state_t;

endpackage

// File: rtl/nvram_spram.sv
// Single-port synchronous byte RAM with a registered, read-first output.
module nvram_spram #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Array itself is never reset so saved contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 8'h00;
    else     rdata <= mem[addr];
  end

endmodule

// File: rtl/nvram_ioctl_bridge.sv
// Arbitrates the 64-byte NVRAM between the core and the ioctl host channel; the core is
// paused while the host downloads a saved table into RAM or uploads RAM to the host.
module nvram_ioctl_bridge #(
  parameter int unsigned ADDR_W      = centipede_pkg::NVRAM_ADDR_W,
  parameter logic [7:0]  NVRAM_INDEX = centipede_pkg::NVRAM_INDEX
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_upload,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_we,
  input  logic [7:0]        core_wdata,
  output logic [7:0]        core_rdata,
  output logic              core_pause,
  output logic              busy
);
  import centipede_pkg::*;

  nvram_state_t state;
  logic         match, dl, ul, addr_in_range, ul_in_range;
  logic [24:0]  ul_addr;
  logic         core_rd;
  logic [7:0]   core_hold;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata, ram_rdata;

  assign match         = (ioctl_index == NVRAM_INDEX);
  assign dl            = ioctl_download & match;
  assign ul            = ioctl_upload & match & ~ioctl_download;
  assign addr_in_range = (ioctl_addr[24:ADDR_W] == '0);
  assign ul_in_range   = (ul_addr[24:ADDR_W] == '0);

  // Core keeps the port through PAUSE so a write already in flight drains.
  always_comb begin
    ram_addr  = core_addr;
    ram_we    = 1'b0;
    ram_wdata = core_wdata;
    case (state)
      IDLE, PAUSE: ram_we = core_we;
      XFER_DL: begin
        ram_addr  = ioctl_addr[ADDR_W-1:0];
        ram_wdata = ioctl_dout;
        ram_we    = ioctl_wr & dl & addr_in_range;
      end
      UL_RD, UL_CAP, UL_HOLD: ram_addr = ioctl_addr[ADDR_W-1:0];
      default: ;
    endcase
  end

  nvram_spram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_sys),
    .rst   (reset),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output belongs to the core only when the read was issued in IDLE; otherwise replay
  // the last core-owned value so core_rdata freezes while paused.
  assign core_rdata = core_rd ? ram_rdata : core_hold;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      core_pause <= 1'b0;
      busy       <= 1'b0;
      ul_addr    <= '0;
      core_rd    <= 1'b1;
      core_hold  <= 8'h00;
    end else begin
      core_rd <= (state == IDLE);
      if (core_rd) core_hold <= ram_rdata;
      case (state)
        IDLE: begin
          if (dl || ul) begin
            state      <= PAUSE;
            ioctl_wait <= 1'b1;
            core_pause <= 1'b1;
            busy       <= 1'b1;
          end
        end
        PAUSE: begin
          if (dl) begin
            state      <= XFER_DL;
            ioctl_wait <= 1'b0;
          end else if (ul) begin
            state <= UL_RD;
          end else begin
            state      <= RELEASE;
            ioctl_wait <= 1'b0;
          end
        end
        XFER_DL: begin
          if (!dl) state <= RELEASE;
        end
        UL_RD: begin
          if (!ul) begin
            state      <= RELEASE;
            ioctl_wait <= 1'b0;
          end else begin
            state   <= UL_CAP;
            ul_addr <= ioctl_addr;
          end
        end
        UL_CAP: begin
          if (!ul) begin
            state      <= RELEASE;
            ioctl_wait <= 1'b0;
          end else begin
            state      <= UL_HOLD;
            ioctl_wait <= 1'b0;
            ioctl_din  <= ul_in_range ? ram_rdata : 8'hFF;
          end
        end
        UL_HOLD: begin
          if (!ul) begin
            state <= RELEASE;
          end else if (ioctl_addr != ul_addr) begin
            state      <= UL_RD;
            ioctl_wait <= 1'b1;
          end
        end
        RELEASE: begin
          state      <= IDLE;
          ioctl_wait <= 1'b0;
          core_pause <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Directed bench for nvram_ioctl_bridge: core access, download, upload, range limits,
// window priority, foreign index and mid-transfer reset.
module tb_nvram_ioctl_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_upload, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index, ioctl_din;
  logic        ioctl_wait;
  logic [5:0]  core_addr;
  logic        core_we;
  logic [7:0]  core_wdata, core_rdata;
  logic        core_pause, busy;

  int n_checks = 0;
  int n_errors = 0;
  int max_wait = 0;
  logic [7:0] exp_mem [64];

  nvram_ioctl_bridge dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_upload   (ioctl_upload),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_din      (ioctl_din),
    .ioctl_wait     (ioctl_wait),
    .core_addr      (core_addr),
    .core_we        (core_we),
    .core_wdata     (core_wdata),
    .core_rdata     (core_rdata),
    .core_pause     (core_pause),
    .busy           (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic core_read(input logic [5:0] a, output logic [7:0] d);
    core_addr = a;
    core_we   = 1'b0;
    tick();
    d = core_rdata;
  endtask

  task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ul_service(input logic [24:0] a, input logic [7:0] exp);
    int n = 0;
    ioctl_addr = a;
    tick();
    while (ioctl_wait && n < 8) begin
      n++;
      tick();
    end
    if (n > max_wait) max_wait = n;
    check("ul_din", {24'h0, ioctl_din}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] d;
    int sum_got, sum_exp;

    reset = 1'b1;
    ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h00; ioctl_index = 8'd0;
    core_addr = '0; core_we = 1'b0; core_wdata = 8'h00;
    #1;
    check("rst_din",   {24'h0, ioctl_din}, 32'h00);
    check("rst_wait",  {31'h0, ioctl_wait}, 32'h0);
    check("rst_rdata", {24'h0, core_rdata}, 32'h00);
    check("rst_pause", {31'h0, core_pause}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: core write then read back
    core_addr = 6'h03; core_we = 1'b1; core_wdata = 8'h5A;
    tick();
    core_read(6'h03, d);
    check("core_rd", {24'h0, d}, 32'h5A);

    // 2: full download, then core readback
    ioctl_index = 8'd4;
    ioctl_download = 1'b1;
    tick();
    check("dl_pause_rise", {31'h0, core_pause}, 32'h1);
    check("dl_wait_pause", {31'h0, ioctl_wait}, 32'h1);
    check("dl_busy",       {31'h0, busy}, 32'h1);
    tick();
    check("dl_wait_xfer",  {31'h0, ioctl_wait}, 32'h0);
    for (int a = 0; a < 64; a++) begin
      exp_mem[a] = 8'(a) ^ 8'hA5;
      dl_write(25'(a), exp_mem[a]);
    end
    ioctl_download = 1'b0;
    tick();
    check("dl_pause_release", {31'h0, core_pause}, 32'h1);
    tick();
    check("dl_pause_fall", {31'h0, core_pause}, 32'h0);
    check("dl_busy_fall",  {31'h0, busy}, 32'h0);
    core_read(6'h3F, d);
    check("dl_rd_3f", {24'h0, d}, 32'h9A);

    // 3: upload every address; a core write while paused must be dropped
    ioctl_upload = 1'b1;
    for (int a = 0; a < 64; a++) begin
      if (a == 10) begin
        core_addr = 6'h05; core_we = 1'b1; core_wdata = 8'h00;
      end
      ul_service(25'(a), exp_mem[a]);
      core_we = 1'b0;
    end
    check("ul_pause", {31'h0, core_pause}, 32'h1);
    check("ul_max_wait", {31'h0, (max_wait <= 3 && max_wait > 0)}, 32'h1);

    // 4: out-of-range upload reads FF, out-of-range download write dropped
    ul_service(25'd64, 8'hFF);
    ioctl_upload = 1'b0;
    tick();
    tick();
    check("ul_end_pause", {31'h0, core_pause}, 32'h0);
    ioctl_download = 1'b1;
    tick();
    tick();
    dl_write(25'd70, 8'h00);
    ioctl_download = 1'b0;
    tick();
    tick();
    sum_got = 0;
    sum_exp = 0;
    for (int a = 0; a < 64; a++) begin
      core_read(6'(a), d);
      sum_got += int'(d);
      sum_exp += int'(exp_mem[a]);
    end
    check("range_sum", 32'(sum_got), 32'(sum_exp));
    core_read(6'h06, d);
    check("no_wrap_6", {24'h0, d}, {24'h0, exp_mem[6]});
    core_read(6'h05, d);
    check("paused_we_drop", {24'h0, d}, {24'h0, exp_mem[5]});

    // 5: both windows -> download path; foreign index ignored
    ioctl_download = 1'b1;
    ioctl_upload   = 1'b1;
    tick();
    tick();
    check("both_wait", {31'h0, ioctl_wait}, 32'h0);
    exp_mem[7] = 8'h11;
    dl_write(25'd7, 8'h11);
    ioctl_download = 1'b0;
    ioctl_upload   = 1'b0;
    tick();
    tick();
    check("both_din", {24'h0, ioctl_din}, 32'hFF);
    core_read(6'h07, d);
    check("both_wr", {24'h0, d}, 32'h11);
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    tick();
    tick();
    check("idx2_pause", {31'h0, core_pause}, 32'h0);
    check("idx2_busy",  {31'h0, busy}, 32'h0);
    dl_write(25'd8, 8'h00);
    ioctl_download = 1'b0;
    tick();
    core_read(6'h08, d);
    check("idx2_nowr", {24'h0, d}, {24'h0, exp_mem[8]});

    // 6: reset in the middle of a download
    ioctl_index    = 8'd4;
    ioctl_download = 1'b1;
    tick();
    tick();
    for (int a = 0; a < 10; a++) begin
      exp_mem[a] = 8'hC0 + 8'(a);
      dl_write(25'(a), exp_mem[a]);
    end
    ioctl_addr = 25'd10;
    ioctl_dout = 8'hEE;
    ioctl_wr   = 1'b1;
    reset      = 1'b1;
    #1;
    check("mid_rst_pause", {31'h0, core_pause}, 32'h0);
    check("mid_rst_busy",  {31'h0, busy}, 32'h0);
    check("mid_rst_wait",  {31'h0, ioctl_wait}, 32'h0);
    check("mid_rst_din",   {24'h0, ioctl_din}, 32'h00);
    check("mid_rst_rdata", {24'h0, core_rdata}, 32'h00);
    tick();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    reset          = 1'b0;
    tick();
    for (int a = 0; a < 11; a++) begin
      core_read(6'(a), d);
      check("mid_rst_keep", {24'h0, d}, {24'h0, exp_mem[a]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
